// File: rtl/shiftregister_univ_if.sv
// Command/status bundle for the universal shift register.
// start is taken only while busy=0; each accepted start produces exactly one done pulse.
interface shiftregister_univ_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             load;
    logic             shift;
    logic             dir;
    logic [1:0]       fill;
    logic             serial_in;
    logic [WIDTH-1:0] I;
    logic             start;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] Q;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic             state_dbg;

    modport master (
        output load, shift, dir, fill, serial_in, I, start, count,
        input  Q, serial_out, busy, done, state_dbg
    );

    modport slave (
        input  load, shift, dir, fill, serial_in, I, start, count,
        output Q, serial_out, busy, done, state_dbg
    );
endinterface

// File: rtl/shiftregister_univ.sv
// Universal shift register: load, left/right shift with four fill modes,
// serial out, and a burst sequencer running count shifts from one start pulse.
module shiftregister_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 CLK,
    input logic                 RST,
    shiftregister_univ_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_so;
    logic             r_busy;
    logic             r_done;
    logic             r_dir;
    logic [1:0]       r_fill;
    logic [CW-1:0]    r_rem;

    logic             w_dir;
    logic [1:0]       w_fill;
    logic             w_fbit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out;

    // A burst uses the direction/fill captured at start, not the live inputs.
    assign w_dir  = (r_state == S_BUSY) ? r_dir  : bus.dir;
    assign w_fill = (r_state == S_BUSY) ? r_fill : bus.fill;

    always_comb begin
        w_fbit    = 1'b0;
        w_shifted = r_q;
        w_out     = 1'b0;
        case (w_fill)
            2'b00:   w_fbit = 1'b0;
            2'b01:   w_fbit = bus.serial_in;
            2'b10:   w_fbit = w_dir ? r_q[0] : r_q[WIDTH-1];
            default: w_fbit = w_dir ? r_q[WIDTH-1] : r_q[0];
        endcase
        if (w_dir) begin
            w_shifted = {w_fbit, r_q[WIDTH-1:1]};
            w_out     = r_q[0];
        end else begin
            w_shifted = {r_q[WIDTH-2:0], w_fbit};
            w_out     = r_q[WIDTH-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_q     <= RESET_VAL;
            r_so    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dir   <= 1'b0;
            r_fill  <= 2'b00;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            r_state <= S_BUSY;
                            r_busy  <= 1'b1;
                            r_dir   <= bus.dir;
                            r_fill  <= bus.fill;
                            r_rem   <= bus.count;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else if (bus.shift) begin
                        r_q  <= w_shifted;
                        r_so <= w_out;
                    end else if (bus.load) begin
                        r_q <= bus.I;
                    end
                end
                default: begin
                    r_q   <= w_shifted;
                    r_so  <= w_out;
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.Q          = r_q;
    assign bus.serial_out = r_so;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.state_dbg  = (r_state == S_BUSY);
endmodule

// File: tb/tb_shiftregister_univ.sv
// Bench for shiftregister_univ: directed scenarios with known values plus
// randomized traffic checked against an integer-arithmetic reference model.
module tb_shiftregister_univ;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    shiftregister_univ_if #(.WIDTH(W)) bus ();

    shiftregister_univ #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: register as an integer, burst as a countdown of pending shifts.
    int         m_q;
    bit         m_so;
    bit         m_busy;
    bit         m_done;
    int         m_left;
    bit         m_bdir;
    logic [1:0] m_bfill;

    function automatic void model_reset();
        m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_left = 0; m_bdir = 0; m_bfill = 2'b00;
    endfunction

    function automatic void model_shift(bit d, logic [1:0] f);
        int msb, lsb, fb;
        msb = (m_q >> (W - 1)) & 1;
        lsb = m_q & 1;
        case (f)
            2'b00:   fb = 0;
            2'b01:   fb = bus.serial_in ? 1 : 0;
            2'b10:   fb = d ? lsb : msb;
            default: fb = d ? msb : lsb;
        endcase
        if (d) begin
            m_so = (lsb == 1);
            m_q  = (m_q >> 1) + fb * (1 << (W - 1));
        end else begin
            m_so = (msb == 1);
            m_q  = (m_q * 2 + fb) % (1 << W);
        end
    endfunction

    function automatic void model_step();
        m_done = 0;
        if (m_busy) begin
            model_shift(m_bdir, m_bfill);
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (bus.start) begin
            if (int'(bus.count) > 0) begin
                m_busy = 1; m_left = int'(bus.count); m_bdir = bus.dir; m_bfill = bus.fill;
            end else begin
                m_done = 1;
            end
        end else if (bus.shift) begin
            model_shift(bus.dir, bus.fill);
        end else if (bus.load) begin
            m_q = int'(bus.I);
        end
    endfunction

    task automatic idle_inputs();
        bus.load = 0; bus.shift = 0; bus.dir = 0; bus.fill = 2'b00; bus.serial_in = 0;
        bus.I = '0; bus.start = 0; bus.count = '0;
    endtask

    // One clock: DUT and model both take the edge; return at the following negedge.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        @(negedge CLK);
        n_vec++;
        if ({bus.Q, bus.serial_out, bus.busy, bus.done} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_initial: Q=%h so=%b busy=%b done=%b, expected all zero",
                     bus.Q, bus.serial_out, bus.busy, bus.done);
        end
        RST = 0;
        bus.load = 1; bus.I = 8'hFF;
        cycle();
        idle_inputs();
        bus.start = 1; bus.count = CW'(5);
        cycle();
        idle_inputs();
        n_vec++;
        if (bus.Q !== 8'hFF || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_busy: Q=%h busy=%b, expected Q=ff busy=1", bus.Q, bus.busy);
        end
        #2 RST = 1;
        #1;
        n_vec++;
        if ({bus.Q, bus.serial_out, bus.busy, bus.done} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_async: Q=%h so=%b busy=%b done=%b, expected all zero",
                     bus.Q, bus.serial_out, bus.busy, bus.done);
        end
        model_reset();
        #1 RST = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_done[%0d]: busy=%b done=%b, expected 0 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_load_shift();
        idle_inputs();
        bus.load = 1; bus.I = 8'hB5;
        cycle();
        n_vec++;
        if (bus.Q !== 8'hB5) begin
            n_err++;
            $display("FAIL load_b5: Q=%h, expected b5", bus.Q);
        end
        idle_inputs();
        bus.shift = 1; bus.dir = 0; bus.fill = 2'b00;
        cycle();
        n_vec++;
        if (bus.Q !== 8'h6A || bus.serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL shift_left_zero: Q=%h so=%b, expected 6a 1", bus.Q, bus.serial_out);
        end
        idle_inputs();
        cycle();
        n_vec++;
        if (bus.Q !== 8'h6A || bus.serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL hold: Q=%h so=%b, expected 6a 1", bus.Q, bus.serial_out);
        end
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp_q [2];
        exp_q[0] = 8'hC0;
        exp_q[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            bus.load = 1; bus.I = 8'h81;
            cycle();
            idle_inputs();
            bus.shift = 1; bus.dir = (i == 0); bus.fill = 2'b10;
            cycle();
            n_vec++;
            if (bus.Q !== exp_q[i] || bus.serial_out !== 1'b1) begin
                n_err++;
                $display("FAIL rotate[dir=%0d]: Q=%h so=%b, expected %h 1", bus.dir, bus.Q, bus.serial_out, exp_q[i]);
            end
        end
    endtask

    task automatic test_arith_right();
        logic [W-1:0] exp_q [3];
        exp_q[0] = 8'hC8; exp_q[1] = 8'hE4; exp_q[2] = 8'hF2;
        idle_inputs();
        bus.load = 1; bus.I = 8'h90;
        cycle();
        idle_inputs();
        bus.shift = 1; bus.dir = 1; bus.fill = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (bus.Q !== exp_q[i] || bus.serial_out !== 1'b0) begin
                n_err++;
                $display("FAIL arith_right[%0d]: Q=%h so=%b, expected %h 0", i, bus.Q, bus.serial_out, exp_q[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [W+1:0] tbl [4];
        tbl[0] = {8'h01, 2'b10}; tbl[1] = {8'h02, 2'b10};
        tbl[2] = {8'h04, 2'b10}; tbl[3] = {8'h08, 2'b01};
        idle_inputs();
        bus.load = 1; bus.I = 8'h01;
        cycle();
        idle_inputs();
        bus.start = 1; bus.count = CW'(3); bus.dir = 0; bus.fill = 2'b00;
        cycle();
        // Everything below must be ignored while the burst runs.
        idle_inputs();
        bus.load = 1; bus.I = 8'hAA; bus.dir = 1; bus.fill = 2'b11; bus.start = 1; bus.count = CW'(7);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({bus.Q, bus.busy, bus.done} !== tbl[i]) begin
                n_err++;
                $display("FAIL burst[%0d]: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b",
                         i, bus.Q, bus.busy, bus.done, tbl[i][W+1:2], tbl[i][1], tbl[i][0]);
            end
            if (i == 2) idle_inputs();
            if (i < 3) cycle();
        end
        cycle();
        n_vec++;
        if ({bus.Q, bus.busy, bus.done} !== {8'h08, 2'b00}) begin
            n_err++;
            $display("FAIL burst_done_clear: Q=%h busy=%b done=%b, expected 08 0 0", bus.Q, bus.busy, bus.done);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.load = 1; bus.I = 8'h0F;
        cycle();
        bus.load = 1; bus.I = 8'h55; bus.shift = 1; bus.dir = 0; bus.fill = 2'b00;
        cycle();
        n_vec++;
        if (bus.Q !== 8'h1E) begin
            n_err++;
            $display("FAIL shift_over_load: Q=%h, expected 1e", bus.Q);
        end
        idle_inputs();
        bus.start = 1; bus.count = '0; bus.shift = 1;
        cycle();
        n_vec++;
        if ({bus.Q, bus.busy, bus.done} !== {8'h1E, 2'b01}) begin
            n_err++;
            $display("FAIL start_count0: Q=%h busy=%b done=%b, expected 1e 0 1", bus.Q, bus.busy, bus.done);
        end
        idle_inputs();
        cycle();
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL count0_done_pulse: done=%b, expected 0", bus.done);
        end
        bus.start = 1; bus.count = CW'(5);
        cycle();
        idle_inputs();
        cycle();
        #2 RST = 1;
        #1;
        model_reset();
        n_vec++;
        if (bus.Q !== 8'h00 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_burst: Q=%h busy=%b, expected 00 0", bus.Q, bus.busy);
        end
        #1 RST = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_done[%0d]: done=%b, expected 0", i, bus.done);
            end
        end
    endtask

    task automatic test_long_burst();
        idle_inputs();
        bus.load = 1; bus.I = 8'hA5;
        cycle();
        idle_inputs();
        bus.start = 1; bus.count = CW'(10); bus.dir = 0; bus.fill = 2'b10;
        cycle();
        idle_inputs();
        repeat (10) cycle();
        n_vec++;
        if ({bus.Q, bus.busy, bus.done} !== {8'h96, 2'b01}) begin
            n_err++;
            $display("FAIL long_rotate: Q=%h busy=%b done=%b, expected 96 0 1", bus.Q, bus.busy, bus.done);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int waited;
        logic [W+2:0] exp;
        idle_inputs();
        bus.start = 1; bus.count = CW'(2); bus.dir = 1; bus.fill = 2'b01; bus.serial_in = 1;
        cycle();
        bus.start = 0;
        waited = 0;
        while (bus.done !== 1'b1 && waited < 10) begin
            cycle();
            waited++;
        end
        n_vec++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done_timeout: done=%b after %0d cycles, expected 1", bus.done, waited);
        end
        bus.start = 1; bus.count = CW'(3); bus.dir = 0; bus.fill = 2'b11;
        cycle();
        bus.start = 0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: busy=%b done=%b, expected 1 0", bus.busy, bus.done);
        end
        for (int i = 0; i < 5; i++) begin
            bus.serial_in = 1'($urandom_range(0, 1));
            cycle();
            exp = {m_q[W-1:0], m_so, m_busy, m_done};
            n_vec++;
            if ({bus.Q, bus.serial_out, bus.busy, bus.done} !== exp) begin
                n_err++;
                $display("FAIL b2b_model[%0d]: Q=%h so=%b busy=%b done=%b, expected Q=%h so=%b busy=%b done=%b",
                         i, bus.Q, bus.serial_out, bus.busy, bus.done, exp[W+2:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W+2:0] exp;
        for (int i = 0; i < 400; i++) begin
            bus.load      = ($urandom_range(0, 3) == 0);
            bus.shift     = 1'($urandom_range(0, 1));
            bus.start     = ($urandom_range(0, 9) == 0);
            bus.count     = CW'($urandom_range(0, 15));
            bus.dir       = 1'($urandom_range(0, 1));
            bus.fill      = 2'($urandom_range(0, 3));
            bus.serial_in = 1'($urandom_range(0, 1));
            bus.I         = W'($urandom);
            cycle();
            exp = {m_q[W-1:0], m_so, m_busy, m_done};
            n_vec++;
            if ({bus.Q, bus.serial_out, bus.busy, bus.done} !== exp) begin
                n_err++;
                $display("FAIL random[%0d]: Q=%h so=%b busy=%b done=%b, expected Q=%h so=%b busy=%b done=%b",
                         i, bus.Q, bus.serial_out, bus.busy, bus.done, exp[W+2:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_arith_right();
        test_burst();
        test_priority();
        test_long_burst();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
